// File: rtl/j1_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : j1_pkg                                                  |
// | Purpose  : Shared decode types and instruction field positions     |
// |            for the J1 Wishbone core.                               |
// | Contents : tag_t (instruction class), op_t (ALU op),               |
// |            state_t with RUN/MEM, ALU field bit positions,          |
// |            decode_tag() helper.                                    |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package j1_pkg;

   typedef enum logic [2:0] {
      TAG_UBRANCH = 3'b000,
      TAG_ZBRANCH = 3'b001,
      TAG_CALL    = 3'b010,
      TAG_ALU     = 3'b011,
      TAG_LIT     = 3'b100
   } tag_t;

   typedef enum logic [3:0] {
      OP_T     = 4'h0, OP_N     = 4'h1, OP_ADD   = 4'h2, OP_AND   = 4'h3,
      OP_OR    = 4'h4, OP_XOR   = 4'h5, OP_INV   = 4'h6, OP_EQ    = 4'h7,
      OP_LT    = 4'h8, OP_SHR   = 4'h9, OP_DEC   = 4'hA, OP_R     = 4'hB,
      OP_LOAD  = 4'hC, OP_SHL   = 4'hD, OP_DEPTH = 4'hE, OP_ULT   = 4'hF
   } op_t;

   typedef logic [0:0] state_t;
   localparam state_t RUN = 1'b0;
   localparam state_t MEM = 1'b1;

   // ALU field positions; the low 13 bits look the same for every W.
   localparam int F_RPC    = 12;
   localparam int F_OP_MSB = 11;
   localparam int F_OP_LSB = 8;
   localparam int F_TN     = 7;
   localparam int F_TR     = 6;
   localparam int F_NT     = 5;
   localparam int F_IE     = 4;
   localparam int F_RD_MSB = 3;
   localparam int F_RD_LSB = 2;
   localparam int F_DD_MSB = 1;
   localparam int F_DD_LSB = 0;

   // Top bit set means literal regardless of the two bits below it.
   function automatic tag_t decode_tag(input logic [2:0] top);
      if (top[2]) return TAG_LIT;
      return tag_t'(top);
   endfunction

endpackage
`default_nettype wire

// File: rtl/j1_stack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : j1_stack                                                |
// | Purpose  : Stack register file, one synchronous write port and     |
// |            one asynchronous read port. Pointer handling and wrap   |
// |            detection live in the core.                             |
// | Ports    : clk, we, waddr, wdata (write) ; raddr -> rdata (read)   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module j1_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 32,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
   end

   assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/j1_core_wb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : j1_core_wb                                              |
// | Purpose  : J1 stack CPU with Wishbone-classic data master, one     |
// |            maskable vectored interrupt and sticky stack-wrap flags.|
// | Ports    : clk, reset (async, active-high)                         |
// |            ibus_adr/ibus_re/ibus_dat : sync ROM, 1-cycle latency   |
// |            wb_cyc/stb/we/adr/dat_o/dat_i/ack : data bus master     |
// |            irq : level interrupt ; dstk_err/rstk_err : wrap flags  |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module j1_core_wb
   import j1_pkg::*;
#(
   parameter int W            = 16,
   parameter int PC_W         = 13,
   parameter int DSTACK_DEPTH = 32,
   parameter int RSTACK_DEPTH = 32,
   parameter int IRQ_VEC      = 1
) (
   input  logic            clk,
   input  logic            reset,
   output logic [PC_W-1:0] ibus_adr,
   output logic            ibus_re,
   input  logic [W-1:0]    ibus_dat,
   output logic            wb_cyc,
   output logic            wb_stb,
   output logic            wb_we,
   output logic [W-2:0]    wb_adr,
   output logic [W-1:0]    wb_dat_o,
   input  logic [W-1:0]    wb_dat_i,
   input  logic            wb_ack,
   input  logic            irq,
   output logic            dstk_err,
   output logic            rstk_err
);

   localparam int DP_W = $clog2(DSTACK_DEPTH);
   localparam int RP_W = $clog2(RSTACK_DEPTH);
   localparam int SH_W = $clog2(W);

   logic [PC_W-1:0] r_pc;
   logic [DP_W-1:0] r_dsp;
   logic [RP_W-1:0] r_rsp;
   logic [W-1:0]    r_t, r_insn;
   logic            r_ie, r_boot, r_dstk_err, r_rstk_err;
   state_t          r_state;

   logic [W-1:0]    w_insn, w_n, w_r, w_alu, w_t_next, w_rstk_wdata;
   tag_t            w_tag;
   op_t             w_op;
   logic            w_is_mem, w_irq_take, w_bus_start, w_commit;
   logic            w_dstk_push, w_rstk_push;
   logic [PC_W-1:0] w_pc_inc, w_pc_next, w_target;
   logic [DP_W:0]   w_dd, w_dsp_sum;
   logic [RP_W:0]   w_rd, w_rsp_sum;

   // While a bus transfer is pending the ROM is not re-read, so the held copy is used.
   assign w_insn   = (r_state == MEM) ? r_insn : ibus_dat;
   assign w_tag    = decode_tag(w_insn[W-1:W-3]);
   assign w_op     = op_t'(w_insn[F_OP_MSB:F_OP_LSB]);
   assign w_target = w_insn[PC_W-1:0];
   assign w_pc_inc = r_pc + PC_W'(1);

   assign w_is_mem    = (w_tag == TAG_ALU) && ((w_op == OP_LOAD) || w_insn[F_NT]);
   // r_boot masks the first presented word after reset release.
   assign w_irq_take  = (r_state == RUN) && irq && r_ie && !r_boot;
   assign w_bus_start = (r_state == RUN) && w_is_mem && !w_irq_take;
   assign w_commit    = !reset && (w_irq_take || ((r_state == RUN) && !w_is_mem) ||
                                   ((r_state == MEM) && wb_ack));

   always_comb begin
      w_alu = r_t;
      case (w_op)
         OP_T:     w_alu = r_t;
         OP_N:     w_alu = w_n;
         OP_ADD:   w_alu = r_t + w_n;
         OP_AND:   w_alu = r_t & w_n;
         OP_OR:    w_alu = r_t | w_n;
         OP_XOR:   w_alu = r_t ^ w_n;
         OP_INV:   w_alu = ~r_t;
         OP_EQ:    w_alu = {W{w_n == r_t}};
         OP_LT:    w_alu = {W{$signed(w_n) < $signed(r_t)}};
         OP_SHR:   w_alu = w_n >> r_t[SH_W-1:0];
         OP_DEC:   w_alu = r_t - W'(1);
         OP_R:     w_alu = w_r;
         OP_LOAD:  w_alu = wb_dat_i;
         OP_SHL:   w_alu = w_n << r_t[SH_W-1:0];
         OP_DEPTH: w_alu = {{(W/2-RP_W){1'b0}}, r_rsp, {(W/2-DP_W){1'b0}}, r_dsp};
         OP_ULT:   w_alu = {W{w_n < r_t}};
         default:  w_alu = r_t;
      endcase
   end

   always_comb begin
      w_pc_next    = r_pc;
      w_t_next     = r_t;
      w_dd         = '0;
      w_rd         = '0;
      w_dstk_push  = 1'b0;
      w_rstk_push  = 1'b0;
      w_rstk_wdata = r_t;
      if (w_irq_take) begin
         // Return address is the discarded word itself so it re-executes.
         w_pc_next    = PC_W'(IRQ_VEC);
         w_rd         = (RP_W+1)'(1);
         w_rstk_push  = 1'b1;
         w_rstk_wdata = W'({r_pc, 1'b0});
      end else if (w_commit) begin
         w_pc_next = w_pc_inc;
         case (w_tag)
            TAG_LIT: begin
               w_t_next    = {1'b0, w_insn[W-2:0]};
               w_dd        = (DP_W+1)'(1);
               w_dstk_push = 1'b1;
            end
            TAG_UBRANCH: w_pc_next = w_target;
            TAG_ZBRANCH: begin
               w_t_next = w_n;
               w_dd     = '1;
               if (r_t == '0) w_pc_next = w_target;
            end
            TAG_CALL: begin
               w_pc_next    = w_target;
               w_rd         = (RP_W+1)'(1);
               w_rstk_push  = 1'b1;
               w_rstk_wdata = W'({w_pc_inc, 1'b0});
            end
            default: begin
               w_t_next    = w_alu;
               w_dd        = {{(DP_W-1){w_insn[F_DD_MSB]}}, w_insn[F_DD_MSB:F_DD_LSB]};
               w_rd        = {{(RP_W-1){w_insn[F_RD_MSB]}}, w_insn[F_RD_MSB:F_RD_LSB]};
               w_dstk_push = w_insn[F_TN];
               w_rstk_push = w_insn[F_TR];
               if (w_insn[F_RPC]) w_pc_next = w_r[PC_W:1];
            end
         endcase
      end
   end

   // One extra bit above the pointer: it is set exactly when the move crosses
   // the DEPTH-1/0 boundary in either direction.
   assign w_dsp_sum = {1'b0, r_dsp} + w_dd;
   assign w_rsp_sum = {1'b0, r_rsp} + w_rd;

   j1_stack #(.WIDTH(W), .DEPTH(DSTACK_DEPTH)) u_dstack (
      .clk   (clk),
      .we    (w_commit && w_dstk_push),
      .waddr (w_dsp_sum[DP_W-1:0]),
      .wdata (r_t),
      .raddr (r_dsp),
      .rdata (w_n)
   );

   j1_stack #(.WIDTH(W), .DEPTH(RSTACK_DEPTH)) u_rstack (
      .clk   (clk),
      .we    (w_commit && w_rstk_push),
      .waddr (w_rsp_sum[RP_W-1:0]),
      .wdata (w_rstk_wdata),
      .raddr (r_rsp),
      .rdata (w_r)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc       <= '0;
         r_dsp      <= '0;
         r_rsp      <= '0;
         r_t        <= '0;
         r_insn     <= '0;
         r_ie       <= 1'b0;
         r_boot     <= 1'b1;
         r_state    <= RUN;
         r_dstk_err <= 1'b0;
         r_rstk_err <= 1'b0;
      end else begin
         r_boot <= 1'b0;
         if (r_state != MEM) r_insn <= ibus_dat;
         if (w_commit) begin
            r_pc       <= w_pc_next;
            r_t        <= w_t_next;
            r_dsp      <= w_dsp_sum[DP_W-1:0];
            r_rsp      <= w_rsp_sum[RP_W-1:0];
            r_dstk_err <= r_dstk_err | w_dsp_sum[DP_W];
            r_rstk_err <= r_rstk_err | w_rsp_sum[RP_W];
            if (w_irq_take)
               r_ie <= 1'b0;
            else if ((w_tag == TAG_ALU) && w_insn[F_RPC] && w_insn[F_IE])
               r_ie <= 1'b1;
         end
         if (w_bus_start)
            r_state <= MEM;
         else if ((r_state == MEM) && wb_ack)
            r_state <= RUN;
      end
   end

   assign ibus_re  = reset || w_commit;
   assign ibus_adr = reset ? '0 : w_pc_next;
   assign wb_cyc   = !reset && ((r_state == MEM) || w_bus_start);
   assign wb_stb   = wb_cyc;
   assign wb_we    = wb_cyc && w_insn[F_NT];
   assign wb_adr   = r_t[W-1:1];
   assign wb_dat_o = w_n;
   assign dstk_err = r_dstk_err;
   assign rstk_err = r_rstk_err;

endmodule
`default_nettype wire
